// File: rtl/coin_acceptor.sv
// Coin sensor front end: synchronises the raw sensor levels, checks each coin's width and
// queues accepted coins, then emits them to the vending machine as one-cycle codes.
module coin_acceptor #(
  parameter int unsigned MIN_W = 3,
  parameter int unsigned MAX_W = 16,
  parameter int unsigned GAP   = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       sense_5,
  input  logic                       sense_10,
  input  logic                       hold,
  output logic [1:0]                 coin,
  output logic                       reject,
  output logic [$clog2(DEPTH):0]     pending,
  output logic                       overflow
);

  localparam int unsigned CW = $clog2(MAX_W + 1) + 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [1:0] Code5  = 2'b01;
  localparam logic [1:0] Code10 = 2'b10;

  typedef enum logic [1:0] {StIdle, StMeas, StJam} state_e;

  // Two-flop synchronisers
  logic s5_meta_q, s5_q, s10_meta_q, s10_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s5_meta_q  <= 1'b0;
      s5_q       <= 1'b0;
      s10_meta_q <= 1'b0;
      s10_q      <= 1'b0;
    end else begin
      s5_meta_q  <= sense_5;
      s5_q       <= s5_meta_q;
      s10_meta_q <= sense_10;
      s10_q      <= s10_meta_q;
    end
  end

  // Measurement FSM
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      code_q, code_d;
  logic            act_hi, opp_hi;
  logic            push, fsm_rej;

  assign act_hi = (code_q == Code5) ? s5_q : s10_q;
  assign opp_hi = (code_q == Code5) ? s10_q : s5_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      code_q  <= Code5;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    unique case (state_q)
      StIdle: begin
        if (s5_q && s10_q) begin
          state_d = StJam;
        end else if (s5_q) begin
          state_d = StMeas;
          code_d  = Code5;
          cnt_d   = CW'(1);
        end else if (s10_q) begin
          state_d = StMeas;
          code_d  = Code10;
          cnt_d   = CW'(1);
        end
      end
      StMeas: begin
        if (opp_hi) begin
          state_d = StJam;
        end else if (act_hi) begin
          // Saturate at MAX_W: one more high cycle is a jam, so cnt never wraps
          if (cnt_q == CW'(MAX_W)) begin
            state_d = StJam;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = StIdle;
        end
      end
      StJam: begin
        if (!s5_q && !s10_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    push    = 1'b0;
    fsm_rej = 1'b0;
    unique case (state_q)
      StIdle: fsm_rej = s5_q && s10_q;
      StMeas: begin
        if (opp_hi) begin
          fsm_rej = 1'b1;
        end else if (act_hi) begin
          fsm_rej = (cnt_q == CW'(MAX_W));
        end else if (cnt_q >= CW'(MIN_W)) begin
          push = 1'b1;
        end else begin
          fsm_rej = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Coin FIFO
  logic [1:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          full, empty, pop, wr_en, drop;
  logic [GW-1:0] gap_q;

  assign full  = (count_q == (PW + 1)'(DEPTH));
  assign empty = (count_q == '0);
  assign pop   = !empty && !hold && (gap_q == '0);
  // A pop in the same cycle frees the slot, so a push is accepted even when full
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 2'b00;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= code_q;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (wr_en && !pop) begin
        count_q <= count_q + (PW + 1)'(1);
      end else if (pop && !wr_en) begin
        count_q <= count_q - (PW + 1)'(1);
      end
    end
  end

  // Output stage
  logic [1:0] coin_q;
  logic       reject_q, overflow_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      coin_q     <= 2'b00;
      reject_q   <= 1'b0;
      overflow_q <= 1'b0;
      gap_q      <= '0;
    end else begin
      coin_q   <= pop ? mem_q[rd_ptr_q] : 2'b00;
      reject_q <= fsm_rej || drop;
      if (drop) begin
        overflow_q <= 1'b1;
      end
      if (pop) begin
        gap_q <= GW'(GAP);
      end else if (gap_q != '0) begin
        gap_q <= gap_q - GW'(1);
      end
    end
  end

  assign coin     = coin_q;
  assign reject   = reject_q;
  assign pending  = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed self-checking bench for coin_acceptor with hand-computed expectations.
module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       sense_5 = 1'b0;
  logic       sense_10 = 1'b0;
  logic       hold = 1'b0;
  logic [1:0] coin;
  logic       reject;
  logic [2:0] pending;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  coin_acceptor #(.MIN_W(3), .MAX_W(16), .GAP(2), .DEPTH(4)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .sense_5  (sense_5),
    .sense_10 (sense_10),
    .hold     (hold),
    .coin     (coin),
    .reject   (reject),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Event recorder: codes seen, reject pulses, minimum idle run between codes
  logic [1:0] log_q[$];
  int cyc = 0;
  int rej_cnt = 0;
  int last_coin = -1;
  int min_gap = 1000;
  bit bad11 = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rstn) begin
      if (coin == 2'b11) bad11 = 1'b1;
      if (coin != 2'b00) begin
        if (last_coin >= 0 && (cyc - last_coin - 1) < min_gap) min_gap = cyc - last_coin - 1;
        last_coin = cyc;
        log_q.push_back(coin);
      end
      if (reject) rej_cnt++;
    end
  end

  task automatic clear_log();
    @(negedge clk);
    #1;
    log_q.delete();
    rej_cnt   = 0;
    last_coin = -1;
    min_gap   = 1000;
  endtask

  // Raw pulse high for w rising edges; returns at the negedge where it falls
  task automatic pulse(input bit ten, input int w);
    @(negedge clk);
    if (ten) sense_10 = 1'b1; else sense_5 = 1'b1;
    repeat (w) @(negedge clk);
    sense_5  = 1'b0;
    sense_10 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle(3);
    checks++; if (coin !== 2'b00) begin errors++; $display("FAIL reset_coin got %b want 00", coin); end
    checks++; if (reject !== 1'b0) begin errors++; $display("FAIL reset_reject got %b want 0", reject); end
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL reset_pending got %0d want 0", pending); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    @(negedge clk);
    rstn = 1'b1;
    idle(2);
  endtask

  task automatic test_single_5();
    logic [1:0] want;
    clear_log();
    pulse(1'b0, 5);
    for (int e = 1; e <= 5; e++) begin
      @(negedge clk);
      want = (e == 4) ? 2'b01 : 2'b00;
      checks++;
      if (coin !== want) begin
        errors++; $display("FAIL latency_edge%0d got %b want %b", e, coin, want);
      end
      if (e == 3) begin
        checks++;
        if (pending !== 3'd1) begin errors++; $display("FAIL push_pending got %0d want 1", pending); end
      end
    end
    idle(4);
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL single_pending got %0d want 0", pending); end
    checks++; if (rej_cnt !== 0) begin errors++; $display("FAIL single_reject got %0d want 0", rej_cnt); end
    checks++; if (log_q.size() !== 1) begin errors++; $display("FAIL single_count got %0d want 1", log_q.size()); end
  endtask

  task automatic test_back_to_back();
    int sum;
    clear_log();
    for (int i = 0; i < 3; i++) pulse(1'b1, 4);
    idle(20);
    sum = 0;
    foreach (log_q[i]) sum += (log_q[i] == 2'b10) ? 10 : (log_q[i] == 2'b01) ? 5 : 0;
    checks++; if (log_q.size() !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", log_q.size()); end
    checks++; if (sum !== 30) begin errors++; $display("FAIL b2b_sum got %0d want 30", sum); end
    checks++; if (min_gap < 2) begin errors++; $display("FAIL b2b_gap got %0d want >=2", min_gap); end
    checks++; if (rej_cnt !== 0) begin errors++; $display("FAIL b2b_reject got %0d want 0", rej_cnt); end
  endtask

  task automatic test_width();
    clear_log();
    pulse(1'b0, 2);
    idle(8);
    checks++; if (rej_cnt !== 1) begin errors++; $display("FAIL w2_reject got %0d want 1", rej_cnt); end
    pulse(1'b0, 17);
    idle(8);
    checks++; if (rej_cnt !== 2) begin errors++; $display("FAIL w17_reject got %0d want 2", rej_cnt); end
    checks++; if (log_q.size() !== 0) begin errors++; $display("FAIL w_bad_coin got %0d want 0", log_q.size()); end
    pulse(1'b0, 3);
    idle(8);
    pulse(1'b0, 16);
    idle(8);
    checks++; if (log_q.size() !== 2) begin errors++; $display("FAIL w_edge_count got %0d want 2", log_q.size()); end
    checks++; if (rej_cnt !== 2) begin errors++; $display("FAIL w_edge_reject got %0d want 2", rej_cnt); end
    pulse(1'b0, 20);
    idle(8);
    checks++; if (rej_cnt !== 3) begin errors++; $display("FAIL w20_reject got %0d want 3", rej_cnt); end
    checks++; if (log_q.size() !== 2) begin errors++; $display("FAIL w20_coin got %0d want 2", log_q.size()); end
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL w20_pending got %0d want 0", pending); end
  endtask

  task automatic test_conflict();
    clear_log();
    @(negedge clk);
    sense_5  = 1'b1;
    sense_10 = 1'b1;
    idle(5);
    sense_5  = 1'b0;
    sense_10 = 1'b0;
    idle(8);
    checks++; if (rej_cnt !== 1) begin errors++; $display("FAIL both_reject got %0d want 1", rej_cnt); end
    sense_5 = 1'b1;
    idle(3);
    sense_10 = 1'b1;
    idle(3);
    sense_5  = 1'b0;
    sense_10 = 1'b0;
    idle(8);
    checks++; if (rej_cnt !== 2) begin errors++; $display("FAIL mid_reject got %0d want 2", rej_cnt); end
    checks++; if (log_q.size() !== 0) begin errors++; $display("FAIL conflict_coin got %0d want 0", log_q.size()); end
  endtask

  task automatic test_overflow();
    logic [1:0] want[4];
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b10; want[3] = 2'b01;
    clear_log();
    hold = 1'b1;
    pulse(1'b0, 4); idle(2);
    pulse(1'b1, 4); idle(2);
    pulse(1'b1, 4); idle(2);
    pulse(1'b0, 4); idle(2);
    pulse(1'b0, 4);
    idle(6);
    checks++; if (pending !== 3'd4) begin errors++; $display("FAIL ovf_pending got %0d want 4", pending); end
    checks++; if (rej_cnt !== 1) begin errors++; $display("FAIL ovf_reject got %0d want 1", rej_cnt); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
    checks++; if (log_q.size() !== 0) begin errors++; $display("FAIL ovf_held got %0d want 0", log_q.size()); end
    hold = 1'b0;
    idle(20);
    checks++; if (log_q.size() !== 4) begin errors++; $display("FAIL drain_count got %0d want 4", log_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < log_q.size()) begin
        checks++;
        if (log_q[i] !== want[i]) begin
          errors++; $display("FAIL drain_order%0d got %b want %b", i, log_q[i], want[i]);
        end
      end
    end
    checks++; if (min_gap !== 2) begin errors++; $display("FAIL drain_gap got %0d want 2", min_gap); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL drain_pending got %0d want 0", pending); end
  endtask

  task automatic test_async_reset();
    clear_log();
    @(negedge clk);
    sense_5 = 1'b1;
    idle(4);
    #2;
    rstn    = 1'b0;
    sense_5 = 1'b0;
    #1;
    checks++; if (coin !== 2'b00) begin errors++; $display("FAIL ar_meas_coin got %b want 00", coin); end
    checks++; if (reject !== 1'b0) begin errors++; $display("FAIL ar_meas_reject got %b want 0", reject); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ar_overflow got %b want 0", overflow); end
    @(negedge clk);
    rstn = 1'b1;
    idle(6);
    checks++; if (rej_cnt !== 0) begin errors++; $display("FAIL ar_discard_reject got %0d want 0", rej_cnt); end
    hold = 1'b1;
    pulse(1'b1, 4); idle(2);
    pulse(1'b0, 4);
    idle(6);
    checks++; if (pending !== 3'd2) begin errors++; $display("FAIL ar_fill got %0d want 2", pending); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL ar_pending got %0d want 0", pending); end
    checks++; if (coin !== 2'b00) begin errors++; $display("FAIL ar_fifo_coin got %b want 00", coin); end
    @(negedge clk);
    rstn = 1'b1;
    hold = 1'b0;
    idle(4);
    checks++; if (log_q.size() !== 0) begin errors++; $display("FAIL ar_flushed got %0d want 0", log_q.size()); end
    pulse(1'b1, 5);
    idle(10);
    checks++; if (log_q.size() !== 1) begin errors++; $display("FAIL ar_after_count got %0d want 1", log_q.size()); end
    if (log_q.size() > 0) begin
      checks++;
      if (log_q[0] !== 2'b10) begin errors++; $display("FAIL ar_after_code got %b want 10", log_q[0]); end
    end
    checks++; if (rej_cnt !== 0) begin errors++; $display("FAIL ar_reject got %0d want 0", rej_cnt); end
    checks++; if (bad11 !== 1'b0) begin errors++; $display("FAIL code11 got %b want 0", bad11); end
  endtask

  initial begin
    test_reset();
    test_single_5();
    test_back_to_back();
    test_width();
    test_conflict();
    test_overflow();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Front-end coin validator that produces the `coin[1:0]` code stream consumed by `VendingMachine`.
- Takes raw, asynchronous level outputs from the 5-won and 10-won coin sensors, synchronises and width-qualifies them, and rejects malformed events.
- Queues accepted coins in a small FIFO.
- Emits each coin to the vending machine as a single-cycle code (01 = 5 won, 10 = 10 won), spaced by idle cycles and held off while the machine is busy.

Parameters:
- MIN_W, 3: minimum synchronised high width, in cycles, for a valid coin.
- MAX_W, 16: maximum valid width; a longer pulse is a jam.
- GAP, 2: minimum coin=00 cycles between two emitted codes.
- DEPTH, 4: FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- sense_5  input  1  raw 5-won sensor, high while a coin passes, asynchronous to clk.
- sense_10  input  1  raw 10-won sensor, same convention.
- hold  input  1  downstream busy; no code is emitted while high.
- coin  output  2  registered code to VendingMachine: 00 idle, 01 5 won, 10 10 won; never 11.
- reject  output  1  one-cycle pulse per rejected or dropped coin event.
- pending  output  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  output  1  sticky; set when an accepted coin is dropped because the FIFO is full; cleared only by reset.

Behaviour:
- **Reset (rstn=0, asynchronous):**
  - Outputs: coin=00, reject=0, pending=0, overflow=0.
  - Internals: FSM=IDLE, synchronisers=0, FIFO empty, gap counter=0.
  - A partially measured coin is discarded with no reject pulse.
- **Synchronisation:** each sense input passes through a 2-flop synchroniser; s5 and s10 denote the synchronised values. All measurement uses s5 and s10 only.
- **Measurement FSM:**
  - IDLE:
    - s5 & s10 -> JAM, with a reject pulse.
    - s5 only -> MEAS, code=01, cnt=1.
    - s10 only -> MEAS, code=10, cnt=1.
  - MEAS:
    - The opposite sensor rises -> JAM, reject.
    - Active sensor still high -> cnt increments. When cnt would exceed MAX_W -> JAM, reject.
    - Active sensor falls -> if MIN_W <= cnt <= MAX_W, push code, then IDLE. Otherwise reject, then IDLE.
  - JAM: wait until s5=0 and s10=0, then IDLE. No further rejects while in JAM.
- **Width rule:** cnt equals the number of clk cycles the synchronised sensor was high. It is `$clog2(MAX_W+1)+1` bits wide and never wraps.
- **Push timing:** the push occurs on the edge at which the FSM observes the fall.
- **FIFO:**
  - Push when not full: entry stored, pending+1.
  - Push when full without a pop in the same cycle: entry dropped, reject pulses, overflow set.
  - Push and pop in the same cycle: always accepted, including when full; pending unchanged.
  - Pop only when non-empty.
- **Output stage:**
  - A pop occurs when FIFO non-empty, hold=0, and gap counter=0.
  - On a pop, coin takes the popped code for exactly one cycle, then returns to 00. The gap counter loads GAP and decrements to 0 while coin=00.
  - hold sampled high blocks a pop in that cycle only; it never truncates an emitted code.
- **Latency:** with FIFO empty, hold=0, and gap=0, coin asserts on the 4th rising edge after raw sense falls, counting the first edge that samples it low as edge 1.
- **Reject output:** reject is registered. At most one reject pulse per cycle; a simultaneous FSM reject and FIFO drop cannot occur because each push is a single event.

Test Plan:
1. Reset, then 5-won pulse of 5 cycles, hold=0 -> exactly one cycle of coin=01, 4 edges after sense falls; pending returns to 0; no reject.
2. Three back-to-back 10-won pulses of 4 cycles with 1-cycle spacing -> three coin=10 pulses, each separated by at least 2 cycles of 00; sum equals 30 won at the VendingMachine.
3. Widths of 2 and 17 cycles on sense_5 -> one reject pulse each; no push. Width 20 -> single reject at cnt=17; FSM stays in JAM until release; no coin.
4. sense_5 and sense_10 high together, and separately sense_10 rising mid-measurement of a 5-won coin -> one reject each; coin stays 00.
5. hold=1 while 5 valid coins arrive -> pending saturates at 4, fifth coin gives reject and overflow=1. Release hold -> 4 codes emitted in arrival order; overflow remains 1.
6. Assert rstn=0 mid-measurement and with pending=2 -> coin=00, pending=0, and no reject, all immediately (asynchronous). After release, a new valid coin is emitted normally.
